// File: rtl/iob2axi_rd_multi.sv
// iob2axi_rd_multi: AXI4 read bridge for a single multi-burst read command.
// A command (byte address, word count) is split into consecutive INCR bursts,
// each capped by MAX_BURST and, when IOB2AXI_RD_4K_SPLIT_EN is defined, by
// 4 KB boundaries. Only one burst is outstanding at a time. Returned beats pass
// straight through onto a native write port with an incrementing byte address.
//
// Optional feature macro: IOB2AXI_RD_4K_SPLIT_EN (bursts never cross 4 KB).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run, addr, length   command; accepted when run & ready; length 0 is a no-op
//   ready, error        idle flag; sticky error for the last command
//   m_axi_ar*           AXI4 read address channel (single ID, constant attrs)
//   m_axi_r*            AXI4 read data channel
//   m_valid, m_addr,    native write side; m_ready back-pressures rready
//   m_wdata, m_wstrb,
//   m_ready
module iob2axi_rd_multi #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned XFER_W    = 16,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [XFER_W-1:0]     length,
  output logic                  ready,
  output logic                  error,
  output logic [0:0]            m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [0:0]            m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [0:0]            m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned Size  = $clog2(Bytes);
  // Wide enough for remain, MAX_BURST and the 13-bit distance to a 4 KB edge.
  localparam int unsigned CntW  = (XFER_W > 13) ? XFER_W + 1 : 14;
  localparam logic [ADDR_W-1:0] AlignMask = ~(ADDR_W'(Bytes - 1));
  localparam logic [ADDR_W-1:0] AddrInc   = ADDR_W'(Bytes);

`ifdef IOB2AXI_RD_4K_SPLIT_EN
  localparam bit Split4k = 1'b1;
`else
  localparam bit Split4k = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [XFER_W-1:0]   remain_q, remain_d;
  logic [8:0]          bcnt_q, bcnt_d;
  logic [8:0]          beats_q, beats_d;
  logic                error_q, error_d;

  logic                beat_ok;
  logic                last_beat;
  logic [ADDR_W-1:0]   addr_aligned;
  logic                unused_rid;

  // Beats for the next burst: min(remain, MAX_BURST[, words to 4 KB edge]).
  function automatic logic [8:0] calc_beats(input logic [ADDR_W-1:0] a,
                                             input logic [XFER_W-1:0] r);
    logic [CntW-1:0] lim;
    logic [CntW-1:0] rem;
    logic [CntW-1:0] to4k;
    lim = CntW'(MAX_BURST);
    rem = '0;
    rem[XFER_W-1:0] = r;
    to4k = CntW'((13'd4096 - {1'b0, a[11:0]}) >> Size);
    if (Split4k && (to4k < lim)) lim = to4k;
    if (rem < lim) lim = rem;
    return 9'(lim);
  endfunction

  assign addr_aligned = addr & AlignMask;
  assign beat_ok      = (state_q == StData) && m_axi_rvalid && m_ready;
  assign last_beat    = (bcnt_q == (beats_q - 9'd1));
  assign unused_rid   = ^m_axi_rid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      remain_q   <= '0;
      bcnt_q     <= '0;
      beats_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      bcnt_q     <= bcnt_d;
      beats_q    <= beats_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    bcnt_d     = bcnt_q;
    beats_d    = beats_q;
    error_d    = error_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          error_d = 1'b0;
          if (length != '0) begin
            cur_addr_d = addr_aligned;
            remain_d   = length;
            beats_d    = calc_beats(addr_aligned, length);
            state_d    = StAddr;
          end
        end
      end
      StAddr: begin
        if (m_axi_arready) begin
          state_d = StData;
          bcnt_d  = '0;
        end
      end
      StData: begin
        if (beat_ok) begin
          remain_d   = remain_q - 1'b1;
          cur_addr_d = cur_addr_q + AddrInc;
          bcnt_d     = bcnt_q + 9'd1;
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          // rlast must coincide with the final beat of the burst we asked for.
          if (m_axi_rlast != last_beat) error_d = 1'b1;
          // Burst length is owned by us; rlast never ends a burst early.
          if (last_beat) begin
            if (remain_d != '0) begin
              state_d = StAddr;
              beats_d = calc_beats(cur_addr_d, remain_d);
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready         = (state_q == StIdle);
  assign error         = error_q;

  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = cur_addr_q;
  assign m_axi_arlen   = 8'(beats_q - 9'd1);
  assign m_axi_arsize  = 3'(Size);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd2;
  assign m_axi_arprot  = 3'd2;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = (state_q == StAddr);
  assign m_axi_rready  = (state_q == StData) && m_ready;

  assign m_valid       = (state_q == StData) && m_axi_rvalid;
  assign m_addr        = cur_addr_q;
  assign m_wdata       = m_axi_rdata;
  assign m_wstrb       = '1;

endmodule

// File: tb/tb_iob2axi_rd_multi.sv
// Directed bench for iob2axi_rd_multi with a one-burst AXI read slave model.
// Inputs change on the falling edge; the slave/monitor updates at +1 and
// samples handshakes at +2, the main sequence checks at +3.
module tb_iob2axi_rd_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] addr;
  logic [15:0] length;
  logic        ready, error;
  logic [0:0]  arid, arlock;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;

  always #5 clk = ~clk;

  iob2axi_rd_multi #(
    .ADDR_W(32), .DATA_W(32), .XFER_W(16), .MAX_BURST(256)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .addr(addr), .length(length),
    .ready(ready), .error(error),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready)
  );

  // Fault injection knobs (command-relative beat index, -1 = off).
  int err_beat   = -1;
  int early_last = -1;

  // Slave model / monitor state.
  int          cyc = 0;
  logic        ar_hs_q = 1'b0, r_hs_q = 1'b0;
  logic        s_active = 1'b0;
  int          s_bidx = 0, s_blen = 0, ar_len_last = 0;
  int          cmd_beat = 0;
  int          ar_cnt = 0, beat_cnt = 0;
  logic [31:0] ar_addr_log [16];
  int          ar_len_log [16];
  logic [31:0] beat_addr_log [1024];
  logic [31:0] beat_data_log [1024];
  int          last_beat_cyc = 0, ready_rise_cyc = 0;
  logic        ready_prev = 1'b0;
  int          mirror_bad = 0;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      s_active = 1'b0;
      s_bidx   = 0;
      ar_hs_q  = 1'b0;
      r_hs_q   = 1'b0;
    end else if (ar_hs_q) begin
      s_active = 1'b1;
      s_bidx   = 0;
      s_blen   = ar_len_last;
    end else if (r_hs_q) begin
      s_bidx++;
      cmd_beat++;
      if (s_bidx > s_blen) s_active = 1'b0;
    end
    rvalid = s_active;
    rlast  = s_active && ((early_last >= 0) ? (cmd_beat == early_last) : (s_bidx == s_blen));
    rresp  = (s_active && (cmd_beat == err_beat)) ? 2'd2 : 2'd0;
    rdata  = 32'hA500_0000 | 32'(cmd_beat);
    #1;
    if (run && ready) begin
      cmd_beat = 0;
      ar_cnt   = 0;
      beat_cnt = 0;
    end
    ar_hs_q = arvalid && arready;
    if (ar_hs_q) begin
      ar_len_last = int'(arlen);
      if (ar_cnt < 16) begin
        ar_addr_log[ar_cnt] = araddr;
        ar_len_log[ar_cnt]  = int'(arlen);
      end
      ar_cnt++;
    end
    r_hs_q = rvalid && rready;
    if (r_hs_q) begin
      if (beat_cnt < 1024) begin
        beat_addr_log[beat_cnt] = m_addr;
        beat_data_log[beat_cnt] = m_wdata;
      end
      beat_cnt++;
      last_beat_cyc = cyc;
    end
    if (rvalid && !rst && ((rready !== m_ready) || (m_valid !== 1'b1))) mirror_bad++;
    if (ready && !ready_prev) ready_rise_cyc = cyc;
    ready_prev = ready;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [15:0] l);
    @(negedge clk);
    addr   = a;
    length = l;
    run    = 1'b1;
    @(negedge clk);
    run    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!ready && n < 2000);
    check(tag, 64'(ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; addr = '0; length = '0; m_ready = 1'b1; arready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    // Reset state and constant AR attributes.
    check("rst_ready",   64'(ready),   64'd1);
    check("rst_error",   64'(error),   64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready",  64'(rready),  64'd0);
    check("rst_mvalid",  64'(m_valid), 64'd0);
    check("arsize",      64'(arsize),  64'd2);
    check("arburst",     64'(arburst), 64'd1);
    check("arcache",     64'(arcache), 64'd2);
    check("arprot",      64'(arprot),  64'd2);
    check("wstrb",       64'(m_wstrb), 64'hF);
    @(negedge clk);
    rst = 1'b0;

    // Single burst of 10 words at 0x100.
    start_cmd(32'h100, 16'd10);
    wait_idle("t1_idle");
    check("t1_ar_cnt",   64'(ar_cnt),           64'd1);
    check("t1_araddr",   64'(ar_addr_log[0]),   64'h100);
    check("t1_arlen",    64'(ar_len_log[0]),    64'd9);
    check("t1_beats",    64'(beat_cnt),         64'd10);
    check("t1_maddr0",   64'(beat_addr_log[0]), 64'h100);
    check("t1_maddr9",   64'(beat_addr_log[9]), 64'h124);
    check("t1_wdata0",   64'(beat_data_log[0]), 64'hA500_0000);
    check("t1_wdata9",   64'(beat_data_log[9]), 64'hA500_0009);
    check("t1_error",    64'(error),            64'd0);
    check("t1_rdy_lat",  64'(ready_rise_cyc - last_beat_cyc), 64'd1);

    // 600 words split into 256+256+88.
    start_cmd(32'h0, 16'd600);
    wait_idle("t2_idle");
    check("t2_ar_cnt",   64'(ar_cnt),             64'd3);
    check("t2_araddr0",  64'(ar_addr_log[0]),     64'h000);
    check("t2_arlen0",   64'(ar_len_log[0]),      64'd255);
    check("t2_araddr1",  64'(ar_addr_log[1]),     64'h400);
    check("t2_arlen1",   64'(ar_len_log[1]),      64'd255);
    check("t2_araddr2",  64'(ar_addr_log[2]),     64'h800);
    check("t2_arlen2",   64'(ar_len_log[2]),      64'd87);
    check("t2_beats",    64'(beat_cnt),           64'd600);
    check("t2_maddr599", 64'(beat_addr_log[599]), 64'h95C);
    check("t2_error",    64'(error),              64'd0);

    // 8 words starting 16 bytes below a 4 KB boundary.
    start_cmd(32'hFF0, 16'd8);
    wait_idle("t3_idle");
    check("t3_beats",    64'(beat_cnt),         64'd8);
    check("t3_araddr0",  64'(ar_addr_log[0]),   64'hFF0);
`ifdef IOB2AXI_RD_4K_SPLIT_EN
    check("t3_ar_cnt",   64'(ar_cnt),           64'd2);
    check("t3_arlen0",   64'(ar_len_log[0]),    64'd3);
    check("t3_araddr1",  64'(ar_addr_log[1]),   64'h1000);
    check("t3_arlen1",   64'(ar_len_log[1]),    64'd3);
`else
    check("t3_ar_cnt",   64'(ar_cnt),           64'd1);
    check("t3_arlen0",   64'(ar_len_log[0]),    64'd7);
`endif
    check("t3_maddr7",   64'(beat_addr_log[7]), 64'h100C);

    // Back-pressure: m_ready toggles every cycle.
    mirror_bad = 0;
    start_cmd(32'h200, 16'd4);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      m_ready = ~m_ready;
      #3;
      if (ready) break;
    end
    check("t4_idle",     64'(ready),            64'd1);
    m_ready = 1'b1;
    check("t4_beats",    64'(beat_cnt),         64'd4);
    check("t4_maddr1",   64'(beat_addr_log[1]), 64'h204);
    check("t4_maddr3",   64'(beat_addr_log[3]), 64'h20C);
    check("t4_mirror",   64'(mirror_bad),       64'd0);

    // SLVERR on beat 2 makes error sticky until the next accepted run.
    err_beat = 1;
    start_cmd(32'h300, 16'd4);
    wait_idle("t5_idle");
    check("t5_error",    64'(error),            64'd1);
    repeat (3) @(negedge clk);
    #3;
    check("t5_sticky",   64'(error),            64'd1);
    err_beat = -1;
    start_cmd(32'h304, 16'd1);
    wait_idle("t5b_idle");
    check("t5b_error",   64'(error),            64'd0);
    check("t5b_beats",   64'(beat_cnt),         64'd1);

    // rlast on beat 3 of 4: flagged, but the burst still runs its 4 beats.
    early_last = 2;
    start_cmd(32'h400, 16'd4);
    wait_idle("t5c_idle");
    check("t5c_error",   64'(error),            64'd1);
    check("t5c_beats",   64'(beat_cnt),         64'd4);
    early_last = -1;

    // length 0: clears error, no AXI activity.
    start_cmd(32'h500, 16'd0);
    #3;
    check("t5d_ready",   64'(ready),            64'd1);
    check("t5d_error",   64'(error),            64'd0);
    repeat (3) @(negedge clk);
    #3;
    check("t5d_ar_cnt",  64'(ar_cnt),           64'd0);

    // Reset during beat 2 of 8.
    start_cmd(32'h600, 16'd8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #3;
      if (beat_cnt >= 1) break;
    end
    check("t6_beat1",    64'(beat_cnt),         64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("t6_ready",    64'(ready),            64'd1);
    check("t6_arvalid",  64'(arvalid),          64'd0);
    check("t6_rready",   64'(rready),           64'd0);
    check("t6_mvalid",   64'(m_valid),          64'd0);
    rst = 1'b0;
    // Unaligned address is forced down to a word boundary.
    start_cmd(32'h703, 16'd2);
    wait_idle("t6b_idle");
    check("t6b_ar_cnt",  64'(ar_cnt),           64'd1);
    check("t6b_araddr",  64'(ar_addr_log[0]),   64'h700);
    check("t6b_arlen",   64'(ar_len_log[0]),    64'd1);
    check("t6b_beats",   64'(beat_cnt),         64'd2);
    check("t6b_maddr1",  64'(beat_addr_log[1]), 64'h704);
    check("t6b_error",   64'(error),            64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
